// File: rtl/freq_div_core.sv
// Programmable divider: one-cycle tick every eff=max(DivN,1) enabled cycles plus a half-rate square wave.
// Optional FREQ_DIV_TICKCNT_EN adds a 4-bit wrapping tick counter output for a seven-segment digit.
module freq_div_core #(
   parameter int WIDTH             = 32,
   parameter int RESTART_ON_CHANGE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] DivN,
`ifdef FREQ_DIV_TICKCNT_EN
   output logic [3:0]       tick_cnt,
`endif
   output logic             tick,
   output logic             div_clk,
   output logic             busy_restart
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] eff;
   logic             terminal;
   logic             changed;
   logic             restart;

   // DivN of zero is treated as one so the terminal compare never underflows.
   always_comb begin
      eff      = (div_q == '0) ? ONE : div_q;
      terminal = (cnt == (eff - ONE));
      changed  = (DivN != div_q);
      restart  = (RESTART_ON_CHANGE != 0) && changed;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         div_q        <= DivN;
         tick         <= 1'b0;
         div_clk      <= 1'b0;
         busy_restart <= 1'b0;
      end else if (!en) begin
         tick         <= 1'b0;
         busy_restart <= 1'b0;
      end else if (restart) begin
         // A restart outranks a coincident terminal count: no tick this cycle.
         div_q        <= DivN;
         cnt          <= '0;
         tick         <= 1'b0;
         busy_restart <= 1'b1;
      end else if (terminal) begin
         cnt          <= '0;
         tick         <= 1'b1;
         div_clk      <= ~div_clk;
         busy_restart <= 1'b0;
         if (RESTART_ON_CHANGE == 0) begin
            div_q <= DivN;
         end
      end else begin
         cnt          <= cnt + ONE;
         tick         <= 1'b0;
         busy_restart <= 1'b0;
      end
   end

`ifdef FREQ_DIV_TICKCNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= 4'd0;
      end else if (en) begin
         if (restart) begin
            tick_cnt <= 4'd0;
         end else if (terminal) begin
            tick_cnt <= tick_cnt + 4'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_freq_div_core.sv
// Directed bench for freq_div_core; a second instance covers the deferred-reload (no restart) mode.
module tb_freq_div_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] DivN;
   logic        tick, div_clk, busy_restart;
   logic        tick_nr, div_clk_nr, busy_restart_nr;
`ifdef FREQ_DIV_TICKCNT_EN
   logic [3:0]  tick_cnt, tick_cnt_nr;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   freq_div_core #(.WIDTH(32), .RESTART_ON_CHANGE(1)) dut (
      .clk(clk), .rst(rst), .en(en), .DivN(DivN),
`ifdef FREQ_DIV_TICKCNT_EN
      .tick_cnt(tick_cnt),
`endif
      .tick(tick), .div_clk(div_clk), .busy_restart(busy_restart)
   );

   freq_div_core #(.WIDTH(32), .RESTART_ON_CHANGE(0)) dut_nr (
      .clk(clk), .rst(rst), .en(en), .DivN(DivN),
`ifdef FREQ_DIV_TICKCNT_EN
      .tick_cnt(tick_cnt_nr),
`endif
      .tick(tick_nr), .div_clk(div_clk_nr), .busy_restart(busy_restart_nr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [31:0] n, input int cycles);
      rst  = 1'b1;
      en   = 1'b1;
      DivN = n;
      for (int i = 0; i < cycles; i++) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(32'd4, 2);
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
      n_checks++; if (div_clk !== 1'b0) begin n_fail++; $display("FAIL reset_div_clk got %b exp 0", div_clk); end
      n_checks++; if (busy_restart !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_restart); end
   endtask

   task automatic test_div4();
      for (int c = 1; c <= 20; c++) begin
         step();
         n_checks++;
         if (tick !== ((c % 4) == 0)) begin
            n_fail++; $display("FAIL div4_tick c=%0d got %b exp %b", c, tick, ((c % 4) == 0));
         end
         n_checks++;
         if (div_clk !== 1'((c / 4) % 2)) begin
            n_fail++; $display("FAIL div4_div_clk c=%0d got %b exp %0d", c, div_clk, (c / 4) % 2);
         end
      end
   endtask

   task automatic test_div_one();
      for (int k = 0; k < 2; k++) begin
         do_reset(k[31:0], 1);
         for (int c = 1; c <= 6; c++) begin
            step();
            n_checks++;
            if (tick !== 1'b1) begin n_fail++; $display("FAIL divone_tick n=%0d c=%0d got %b exp 1", k, c, tick); end
            n_checks++;
            if (div_clk !== 1'(c % 2)) begin
               n_fail++; $display("FAIL divone_div_clk n=%0d c=%0d got %b exp %0d", k, c, div_clk, c % 2);
            end
         end
      end
   endtask

   task automatic test_restart();
      logic e_tick, e_busy, e_dclk, e_tick_nr, e_dclk_nr;
      do_reset(32'd5, 1);
      for (int c = 1; c <= 11; c++) begin
         if (c == 3) DivN = 32'd3;
         step();
         e_tick    = (c == 6) || (c == 9);
         e_busy    = (c == 3);
         e_dclk    = (c >= 6) && (c < 9);
         e_tick_nr = (c == 5) || (c == 8) || (c == 11);
         e_dclk_nr = ((c >= 5) && (c < 8)) || (c >= 11);
         n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL rst_chg_tick c=%0d got %b exp %b", c, tick, e_tick); end
         n_checks++; if (busy_restart !== e_busy) begin n_fail++; $display("FAIL rst_chg_busy c=%0d got %b exp %b", c, busy_restart, e_busy); end
         n_checks++; if (div_clk !== e_dclk) begin n_fail++; $display("FAIL rst_chg_div_clk c=%0d got %b exp %b", c, div_clk, e_dclk); end
         n_checks++; if (tick_nr !== e_tick_nr) begin n_fail++; $display("FAIL norst_tick c=%0d got %b exp %b", c, tick_nr, e_tick_nr); end
         n_checks++; if (div_clk_nr !== e_dclk_nr) begin n_fail++; $display("FAIL norst_div_clk c=%0d got %b exp %b", c, div_clk_nr, e_dclk_nr); end
         n_checks++; if (busy_restart_nr !== 1'b0) begin n_fail++; $display("FAIL norst_busy c=%0d got %b exp 0", c, busy_restart_nr); end
      end
      // dut is now at its terminal count (cnt=2, eff=3); a change here must restart, not tick
      DivN = 32'd4;
      step();
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL coincide_tick got %b exp 0", tick); end
      n_checks++; if (busy_restart !== 1'b1) begin n_fail++; $display("FAIL coincide_busy got %b exp 1", busy_restart); end
      n_checks++; if (div_clk !== 1'b0) begin n_fail++; $display("FAIL coincide_div_clk got %b exp 0", div_clk); end
      n_checks++; if (tick_nr !== 1'b0) begin n_fail++; $display("FAIL coincide_norst_tick got %b exp 0", tick_nr); end
   endtask

   task automatic test_en_gating();
      logic e_tick, e_dclk;
      do_reset(32'd6, 1);
      for (int c = 1; c <= 24; c++) begin
         en = (c % 2) == 1;
         step();
         e_tick = (c == 11) || (c == 23);
         e_dclk = (c >= 11) && (c < 23);
         n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL engate_tick c=%0d got %b exp %b", c, tick, e_tick); end
         n_checks++; if (div_clk !== e_dclk) begin n_fail++; $display("FAIL engate_div_clk c=%0d got %b exp %b", c, div_clk, e_dclk); end
      end
      // en dropped exactly at terminal count: tick deferred to the first enabled edge
      do_reset(32'd6, 1);
      for (int c = 1; c <= 9; c++) begin
         en = (c <= 5) || (c == 9);
         step();
         e_tick = (c == 9);
         n_checks++; if (tick !== e_tick) begin n_fail++; $display("FAIL endefer_tick c=%0d got %b exp %b", c, tick, e_tick); end
      end
      en = 1'b1;
   endtask

   task automatic test_mid_reset();
      do_reset(32'd10, 1);
      for (int c = 1; c <= 17; c++) step();
      n_checks++; if (div_clk !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_div_clk got %b exp 1", div_clk); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL midrst_tick got %b exp 0", tick); end
      n_checks++; if (div_clk !== 1'b0) begin n_fail++; $display("FAIL midrst_div_clk got %b exp 0", div_clk); end
      n_checks++; if (busy_restart !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy_restart); end
      for (int c = 1; c <= 10; c++) begin
         step();
         n_checks++;
         if (tick !== (c == 10)) begin n_fail++; $display("FAIL midrst_after_tick c=%0d got %b exp %b", c, tick, (c == 10)); end
      end
   endtask

`ifdef FREQ_DIV_TICKCNT_EN
   task automatic test_tick_cnt();
      do_reset(32'd2, 1);
      n_checks++; if (tick_cnt !== 4'd0) begin n_fail++; $display("FAIL tcnt_reset got %0d exp 0", tick_cnt); end
      for (int c = 1; c <= 34; c++) begin
         step();
         n_checks++;
         if (tick_cnt !== 4'((c / 2) % 16)) begin
            n_fail++; $display("FAIL tcnt_count c=%0d got %0d exp %0d", c, tick_cnt, (c / 2) % 16);
         end
      end
      DivN = 32'd3;
      step();
      n_checks++; if (tick_cnt !== 4'd0) begin n_fail++; $display("FAIL tcnt_restart_clear got %0d exp 0", tick_cnt); end
   endtask
`endif

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      DivN = 32'd0;
      test_reset();
      test_div4();
      test_div_one();
      test_restart();
      test_en_gating();
      test_mid_reset();
`ifdef FREQ_DIV_TICKCNT_EN
      test_tick_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
